// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encoding, byte-lane constants.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } arb_state_e;

    localparam logic [3:0] BE_WORD   = 4'hF;
    localparam int         LANE_W    = 8;
    localparam int         NUM_LANES = 4;

    // One-hot byte enable for a little-endian lane index.
    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane steering: store byte enables/replication and load byte extraction with sign extension.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports: lane_i (addr[1:0]), byte_i (byte access), wdata_i/rdata_i (raw words),
//        be_o (byte enables), wdata_o (steered store data), rdata_o (extended load data).
module byte_lane_unit
    import mem_arb_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic        byte_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [LANE_W-1:0] rd_byte;

    always_comb begin
        rd_byte = rdata_i[{lane_i, 3'b000} +: LANE_W];
        if (byte_i) begin
            be_o    = lane_be(lane_i);
            // Replicating the byte on every lane lets memory pick it up under any enable.
            wdata_o = {NUM_LANES{wdata_i[LANE_W-1:0]}};
            rdata_o = {{(32-LANE_W){rd_byte[LANE_W-1]}}, rd_byte};
        end else begin
            be_o    = BE_WORD;
            wdata_o = wdata_i;
            rdata_o = rdata_i;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and data loads/stores.
// Latency: grant and mem_* combinational in cycle T; read rvalid/rdata in T+MEM_LATENCY+1; stores complete in T.
// Backpressure: requests are held until *_gnt; grants only in IDLE, data first unless fetch has starved STARVE_LIMIT times.
//
// Ports: clk/rst (async active-high), halted (blocks new fetch grants),
//        inst_req/addr -> inst_gnt, inst_rvalid/rdata; data_req/we/byte/addr/wdata -> data_gnt, data_rvalid/rdata;
//        mem_en/we/be/addr/wdata -> memory, mem_rdata <- memory; busy = FSM not in IDLE.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halted,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic              data_byte,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic [1:0]        lane_q, lane_d;
    logic              byte_q, byte_d;
    logic              inst_rvalid_q, data_rvalid_q;
    logic [DATA_W-1:0] inst_rdata_q, data_rdata_q;

    logic              inst_elig, starved, grant_ok, read_done;
    logic [1:0]        lane_sel;
    logic              byte_sel;
    logic [3:0]        lane_be_w;
    logic [DATA_W-1:0] steer_wdata, ext_rdata;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^inst_addr[1:0];

    // While a load is in flight the lane unit extracts with the captured
    // attributes; in IDLE it steers the currently requested access.
    assign lane_sel = (state_q == WAIT_D) ? lane_q : data_addr[1:0];
    assign byte_sel = (state_q == WAIT_D) ? byte_q : data_byte;

    byte_lane_unit u_lanes (
        .lane_i  (lane_sel),
        .byte_i  (byte_sel),
        .wdata_i (data_wdata),
        .rdata_i (mem_rdata),
        .be_o    (lane_be_w),
        .wdata_o (steer_wdata),
        .rdata_o (ext_rdata)
    );

    // Grant decision and memory strobes, all in the grant cycle.
    always_comb begin
        inst_elig = inst_req & ~halted;
        starved   = (starve_q == STV_MAX);
        grant_ok  = (state_q == IDLE) & ~rst;
        inst_gnt  = grant_ok & inst_elig & (~data_req | starved);
        data_gnt  = grant_ok & data_req & ~inst_gnt;

        mem_en    = inst_gnt | data_gnt;
        mem_we    = data_gnt & data_we;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (inst_gnt) begin
            mem_be   = BE_WORD;
            mem_addr = {inst_addr[ADDR_W-1:2], 2'b00};
        end else if (data_gnt) begin
            mem_be   = lane_be_w;
            mem_addr = {data_addr[ADDR_W-1:2], 2'b00};
            if (data_we) begin
                mem_wdata = steer_wdata;
            end
        end
    end

    assign read_done = (lat_q == '0);

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        lane_d   = lane_q;
        byte_d   = byte_q;
        starve_d = starve_q;

        case (state_q)
            IDLE: begin
                if (inst_gnt) begin
                    state_d = WAIT_I;
                    lat_d   = LAT_INIT;
                end else if (data_gnt && !data_we) begin
                    state_d = WAIT_D;
                    lat_d   = LAT_INIT;
                    lane_d  = data_addr[1:0];
                    byte_d  = data_byte;
                end
            end
            WAIT_I, WAIT_D: begin
                if (read_done) begin
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counts data wins against a waiting fetch; any fetch grant or a
        // cycle without a fetch request resets the streak.
        if (!inst_req || inst_gnt) begin
            starve_d = '0;
        end else if (data_gnt && !starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            lat_q         <= '0;
            starve_q      <= '0;
            lane_q        <= 2'b00;
            byte_q        <= 1'b0;
            inst_rvalid_q <= 1'b0;
            data_rvalid_q <= 1'b0;
            inst_rdata_q  <= '0;
            data_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            lat_q         <= lat_d;
            starve_q      <= starve_d;
            lane_q        <= lane_d;
            byte_q        <= byte_d;
            inst_rvalid_q <= 1'b0;
            data_rvalid_q <= 1'b0;
            if (state_q == WAIT_I && read_done) begin
                inst_rvalid_q <= 1'b1;
                inst_rdata_q  <= mem_rdata;
            end
            if (state_q == WAIT_D && read_done) begin
                data_rvalid_q <= 1'b1;
                data_rdata_q  <= ext_rdata;
            end
        end
    end

    assign inst_rvalid = inst_rvalid_q;
    assign inst_rdata  = inst_rdata_q;
    assign data_rvalid = data_rvalid_q;
    assign data_rdata  = data_rdata_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural fixed-latency memory.
// Latency: read data checked at grant+MEM_LATENCY+1.
// Backpressure: requests held until grant; expected read data queued at grant, popped on rvalid.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SLIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        halted;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt, inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req, data_we, data_byte;
    logic [31:0] data_addr, data_wdata;
    logic        data_gnt, data_rvalid;
    logic [31:0] data_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [31:0] inst_exp_q[$];
    logic [31:0] data_exp_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)
    ) dut (
        .clk(clk), .rst(rst), .halted(halted),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_byte(data_byte),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(data_gnt),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Behavioural memory: byte-enabled writes, read data appears LAT cycles after mem_en.
    logic [31:0] mem [0:1023];
    logic [31:0] rd_pipe [0:LAT-1];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_dat;
        end else if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[11:2]] : 32'hDEADBEEF;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] dat);
        pl_idx = idx;
        pl_dat = dat;
        pl_en  = 1'b1;
        step();
        pl_en  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; inst_req = 1'b1; data_req = 1'b1; data_we = 1'b1;
        inst_addr = 32'h40; data_addr = 32'h100; data_wdata = 32'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_cnt++; if ({inst_gnt, data_gnt} !== 2'b00) $display("FAIL rst_gnt: got %b want 00", {inst_gnt, data_gnt}); else pass_cnt++;
        chk_cnt++; if ({mem_en, mem_we, mem_be} !== 6'h0) $display("FAIL rst_mem: got %h want 0", {mem_en, mem_we, mem_be}); else pass_cnt++;
        chk_cnt++; if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL rst_mem_bus: got %h want 0", {mem_addr, mem_wdata}); else pass_cnt++;
        chk_cnt++; if ({busy, inst_rvalid, data_rvalid} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {busy, inst_rvalid, data_rvalid}); else pass_cnt++;
        chk_cnt++; if ({inst_rdata, data_rdata} !== 64'h0) $display("FAIL rst_rdata: got %h want 0", {inst_rdata, data_rdata}); else pass_cnt++;
        step();
        inst_req = 1'b0; data_req = 1'b0; data_we = 1'b0; rst = 1'b0;
    endtask

    task automatic test_lone_fetch();
        logic got; int lat; logic [31:0] obs, exp;
        step();
        inst_req = 1'b1; inst_addr = 32'h40;
        @(negedge clk);
        chk_cnt++; if ({inst_gnt, data_gnt, mem_en, mem_we} !== 4'b1010) $display("FAIL fetch_gnt: got %b want 1010", {inst_gnt, data_gnt, mem_en, mem_we}); else pass_cnt++;
        chk_cnt++; if ({mem_addr, mem_be} !== {32'h40, 4'hF}) $display("FAIL fetch_mem: got %h want %h", {mem_addr, mem_be}, {32'h40, 4'hF}); else pass_cnt++;
        if (inst_gnt) inst_exp_q.push_back(32'h2402000A);
        step();
        inst_req = 1'b0;
        got = 1'b0; lat = 0; obs = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk_cnt++; if (busy !== 1'b1) $display("FAIL fetch_busy: got %b want 1", busy); else pass_cnt++;
            end
            if (inst_rvalid) begin got = 1'b1; lat = k; obs = inst_rdata; break; end
        end
        chk_cnt++; if (!got || lat != LAT + 1) $display("FAIL fetch_lat: got T+%0d (seen %b) want T+%0d", lat, got, LAT + 1); else pass_cnt++;
        if (got) begin
            chk_cnt++;
            if (inst_exp_q.size() == 0) $display("FAIL fetch_sb: got rvalid want queued entry");
            else begin
                exp = inst_exp_q.pop_front();
                if (obs !== exp) $display("FAIL fetch_data: got %h want %h", obs, exp); else pass_cnt++;
            end
        end
        @(negedge clk);
        chk_cnt++; if ({inst_rvalid, busy} !== 2'b00) $display("FAIL fetch_pulse: got %b want 00", {inst_rvalid, busy}); else pass_cnt++;
    endtask

    task automatic test_fetch_store();
        logic got; int lat; logic [31:0] obs, exp;
        step();
        inst_req = 1'b1; inst_addr = 32'h80;
        data_req = 1'b1; data_we = 1'b1; data_byte = 1'b0; data_addr = 32'h200; data_wdata = 32'h11223344;
        @(negedge clk);
        chk_cnt++; if ({data_gnt, inst_gnt, mem_we, mem_be} !== 7'b1011111) $display("FAIL prio_store_gnt: got %b want 1011111", {data_gnt, inst_gnt, mem_we, mem_be}); else pass_cnt++;
        chk_cnt++; if ({mem_addr, mem_wdata} !== {32'h200, 32'h11223344}) $display("FAIL prio_store_bus: got %h want %h", {mem_addr, mem_wdata}, {32'h200, 32'h11223344}); else pass_cnt++;
        step();
        data_req = 1'b0; data_we = 1'b0;
        @(negedge clk);
        chk_cnt++; if ({inst_gnt, data_gnt, mem_we, mem_addr} !== {3'b100, 32'h80}) $display("FAIL prio_fetch_next: got %h want %h", {inst_gnt, data_gnt, mem_we, mem_addr}, {3'b100, 32'h80}); else pass_cnt++;
        if (inst_gnt) inst_exp_q.push_back(32'h8C080004);
        step();
        inst_req = 1'b0;
        got = 1'b0; lat = 0; obs = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (inst_rvalid) begin got = 1'b1; lat = k; obs = inst_rdata; break; end
        end
        chk_cnt++; if (!got || lat != LAT + 1) $display("FAIL prio_fetch_lat: got T+%0d (seen %b) want T+%0d", lat, got, LAT + 1); else pass_cnt++;
        if (got) begin
            chk_cnt++;
            if (inst_exp_q.size() == 0) $display("FAIL prio_fetch_sb: got rvalid want queued entry");
            else begin
                exp = inst_exp_q.pop_front();
                if (obs !== exp) $display("FAIL prio_fetch_data: got %h want %h", obs, exp); else pass_cnt++;
            end
        end
    endtask

    task automatic test_starvation();
        logic got; int lat; logic [31:0] obs, exp; logic [1:0] want;
        step();
        inst_req = 1'b1; inst_addr = 32'h40;
        data_req = 1'b1; data_we = 1'b1; data_byte = 1'b0; data_addr = 32'h300; data_wdata = 32'h0;
        for (int i = 0; i <= SLIM; i++) begin
            @(negedge clk);
            want = (i < SLIM) ? 2'b01 : 2'b10;
            chk_cnt++; if ({inst_gnt, data_gnt} !== want) $display("FAIL starve_gnt%0d: got %b want %b", i, {inst_gnt, data_gnt}, want); else pass_cnt++;
            if (i == SLIM && inst_gnt) inst_exp_q.push_back(32'h2402000A);
            step();
            data_addr = data_addr + 32'h4;
        end
        inst_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        got = 1'b0; lat = 0; obs = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (inst_rvalid) begin got = 1'b1; lat = k; obs = inst_rdata; break; end
        end
        chk_cnt++; if (!got || lat != LAT + 1) $display("FAIL starve_fetch_lat: got T+%0d (seen %b) want T+%0d", lat, got, LAT + 1); else pass_cnt++;
        if (got) begin
            chk_cnt++;
            if (inst_exp_q.size() == 0) $display("FAIL starve_sb: got rvalid want queued entry");
            else begin
                exp = inst_exp_q.pop_front();
                if (obs !== exp) $display("FAIL starve_fetch_data: got %h want %h", obs, exp); else pass_cnt++;
            end
        end
    endtask

    typedef struct packed {
        logic        we;
        logic        bt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] wexp;
        logic [31:0] rexp;
    } op_t;

    task automatic test_byte_lanes();
        op_t ops [9];
        logic got; int lat; logic [31:0] obs, exp;
        ops[0] = '{1'b0, 1'b1, 32'h103, 32'h0,        4'b1000, 32'h0,        32'hFFFFFF80};
        ops[1] = '{1'b0, 1'b1, 32'h101, 32'h0,        4'b0010, 32'h0,        32'h0000007F};
        ops[2] = '{1'b1, 1'b1, 32'h101, 32'h123456AB, 4'b0010, 32'hABABABAB, 32'h0};
        ops[3] = '{1'b0, 1'b0, 32'h102, 32'h0,        4'b1111, 32'h0,        32'h80FFAB01};
        ops[4] = '{1'b0, 1'b0, 32'h200, 32'h0,        4'b1111, 32'h0,        32'h11223344};
        ops[5] = '{1'b0, 1'b1, 32'h100, 32'h0,        4'b0001, 32'h0,        32'h00000001};
        ops[6] = '{1'b1, 1'b1, 32'h203, 32'h000000FE, 4'b1000, 32'hFEFEFEFE, 32'h0};
        ops[7] = '{1'b0, 1'b1, 32'h203, 32'h0,        4'b1000, 32'h0,        32'hFFFFFFFE};
        ops[8] = '{1'b0, 1'b0, 32'h201, 32'h0,        4'b1111, 32'h0,        32'hFE223344};
        for (int i = 0; i < 9; i++) begin
            step();
            data_req = 1'b1; data_we = ops[i].we; data_byte = ops[i].bt;
            data_addr = ops[i].addr; data_wdata = ops[i].wdata;
            @(negedge clk);
            chk_cnt++;
            if ({data_gnt, mem_we, mem_be, mem_addr} !== {1'b1, ops[i].we, ops[i].be, ops[i].addr[31:2], 2'b00})
                $display("FAIL lane_req%0d: got %h want %h", i, {data_gnt, mem_we, mem_be, mem_addr},
                         {1'b1, ops[i].we, ops[i].be, ops[i].addr[31:2], 2'b00});
            else pass_cnt++;
            if (ops[i].we) begin
                chk_cnt++; if (mem_wdata !== ops[i].wexp) $display("FAIL lane_wdata%0d: got %h want %h", i, mem_wdata, ops[i].wexp); else pass_cnt++;
            end else if (data_gnt) begin
                data_exp_q.push_back(ops[i].rexp);
            end
            step();
            data_req = 1'b0; data_we = 1'b0; data_byte = 1'b0;
            if (!ops[i].we) begin
                got = 1'b0; lat = 0; obs = '0;
                for (int k = 1; k <= 10; k++) begin
                    @(negedge clk);
                    if (data_rvalid) begin got = 1'b1; lat = k; obs = data_rdata; break; end
                end
                chk_cnt++; if (!got || lat != LAT + 1) $display("FAIL lane_lat%0d: got T+%0d (seen %b) want T+%0d", i, lat, got, LAT + 1); else pass_cnt++;
                if (got) begin
                    chk_cnt++;
                    if (data_exp_q.size() == 0) $display("FAIL lane_sb%0d: got rvalid want queued entry", i);
                    else begin
                        exp = data_exp_q.pop_front();
                        if (obs !== exp) $display("FAIL lane_rdata%0d: got %h want %h", i, obs, exp); else pass_cnt++;
                    end
                end
            end
        end
    endtask

    task automatic test_halt();
        int n_ig, rv_i, dg, rv_d; logic [31:0] ri, rd, exp;
        step();
        halted = 1'b0; inst_req = 1'b1; inst_addr = 32'h40;
        @(negedge clk);
        chk_cnt++; if (inst_gnt !== 1'b1) $display("FAIL halt_first_gnt: got %b want 1", inst_gnt); else pass_cnt++;
        if (inst_gnt) inst_exp_q.push_back(32'h2402000A);
        step();
        halted = 1'b1; data_req = 1'b1; data_we = 1'b0; data_byte = 1'b0; data_addr = 32'h100;
        n_ig = 0; rv_i = 0; dg = 0; rv_d = 0; ri = '0; rd = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (inst_gnt) n_ig++;
            if (inst_rvalid) begin rv_i = k; ri = inst_rdata; end
            if (data_gnt) begin dg = k; data_exp_q.push_back(32'h80FFAB01); end
            if (data_rvalid) begin rv_d = k; rd = data_rdata; end
            step();
            if (dg != 0) data_req = 1'b0;
        end
        inst_req = 1'b0; halted = 1'b0;
        chk_cnt++; if (n_ig != 0) $display("FAIL halt_no_gnt: got %0d grants want 0", n_ig); else pass_cnt++;
        chk_cnt++; if (rv_i != LAT + 1) $display("FAIL halt_inflight_lat: got T+%0d want T+%0d", rv_i, LAT + 1); else pass_cnt++;
        chk_cnt++; if (dg != LAT + 1) $display("FAIL halt_data_gnt_cycle: got T+%0d want T+%0d", dg, LAT + 1); else pass_cnt++;
        chk_cnt++; if (rv_d != 2 * (LAT + 1)) $display("FAIL halt_data_lat: got T+%0d want T+%0d", rv_d, 2 * (LAT + 1)); else pass_cnt++;
        if (rv_i != 0) begin
            chk_cnt++;
            if (inst_exp_q.size() == 0) $display("FAIL halt_inst_sb: got rvalid want queued entry");
            else begin
                exp = inst_exp_q.pop_front();
                if (ri !== exp) $display("FAIL halt_inst_data: got %h want %h", ri, exp); else pass_cnt++;
            end
        end
        if (rv_d != 0) begin
            chk_cnt++;
            if (data_exp_q.size() == 0) $display("FAIL halt_data_sb: got rvalid want queued entry");
            else begin
                exp = data_exp_q.pop_front();
                if (rd !== exp) $display("FAIL halt_data_rdata: got %h want %h", rd, exp); else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int nrv; logic got; int lat; logic [31:0] obs, exp;
        step();
        data_req = 1'b1; data_we = 1'b0; data_byte = 1'b0; data_addr = 32'h100;
        @(negedge clk);
        chk_cnt++; if (data_gnt !== 1'b1) $display("FAIL rstmid_gnt: got %b want 1", data_gnt); else pass_cnt++;
        step();
        data_req = 1'b0; rst = 1'b1;
        nrv = 0;
        @(negedge clk);
        if (data_rvalid) nrv++;
        chk_cnt++; if ({busy, mem_en} !== 2'b00) $display("FAIL rstmid_busy: got %b want 00", {busy, mem_en}); else pass_cnt++;
        step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (data_rvalid) nrv++;
        end
        chk_cnt++; if (nrv != 0) $display("FAIL rstmid_no_rvalid: got %0d pulses want 0", nrv); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_idle: got %b want 0", busy); else pass_cnt++;
        step();
        data_req = 1'b1; data_addr = 32'h200;
        @(negedge clk);
        chk_cnt++; if ({data_gnt, mem_addr} !== {1'b1, 32'h200}) $display("FAIL rstmid_clean_gnt: got %h want %h", {data_gnt, mem_addr}, {1'b1, 32'h200}); else pass_cnt++;
        if (data_gnt) data_exp_q.push_back(32'hFE223344);
        step();
        data_req = 1'b0;
        got = 1'b0; lat = 0; obs = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (data_rvalid) begin got = 1'b1; lat = k; obs = data_rdata; break; end
        end
        chk_cnt++; if (!got || lat != LAT + 1) $display("FAIL rstmid_clean_lat: got T+%0d (seen %b) want T+%0d", lat, got, LAT + 1); else pass_cnt++;
        if (got) begin
            chk_cnt++;
            if (data_exp_q.size() == 0) $display("FAIL rstmid_sb: got rvalid want queued entry");
            else begin
                exp = data_exp_q.pop_front();
                if (obs !== exp) $display("FAIL rstmid_clean_data: got %h want %h", obs, exp); else pass_cnt++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; halted = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_byte = 1'b0; data_addr = '0; data_wdata = '0;
        test_reset();
        preload(10'h010, 32'h2402000A);
        preload(10'h020, 32'h8C080004);
        preload(10'h040, 32'h80FF7F01);
        test_lone_fetch();
        test_fetch_store();
        test_starvation();
        test_byte_lanes();
        test_halt();
        test_reset_mid();
        chk_cnt++;
        if (inst_exp_q.size() != 0 || data_exp_q.size() != 0)
            $display("FAIL sb_drain: got %0d/%0d entries left want 0/0", inst_exp_q.size(), data_exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
